cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the CPU instruction-fetch port and the load/store port.
- Sits between the cpu_top fetch/LSU interfaces and the memory macro.
- Allows one outstanding access at a time.
- Data port has priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 wide.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins; legal range 1..15.

Ports:
- clk, in, 1, clock; all state is updated on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- if_req, in, 1, fetch request.
- if_addr, in, ADDR_W, fetch address.
- if_gnt, out, 1, fetch request accepted this cycle.
- if_rvalid, out, 1, fetch data valid, one-cycle pulse.
- if_rdata, out, DATA_W, fetch data.
- d_req, in, 1, data request.
- d_we, in, 1, 1 = write, 0 = read.
- d_be, in, DATA_W/8, byte enables for writes.
- d_addr, in, ADDR_W, data address.
- d_wdata, in, DATA_W, write data.
- d_gnt, out, 1, data request accepted this cycle.
- d_rvalid, out, 1, read data valid or write-complete, one-cycle pulse.
- d_rdata, out, DATA_W, read data; 0 on write completion.
- mem_en, out, 1, memory access strobe, one cycle.
- mem_we, out, 1, memory write.
- mem_be, out, DATA_W/8, memory byte enables.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data; valid MEM_LAT cycles after mem_en.
- busy, out, 1, a transaction is outstanding.

Behaviour:

States:
- IDLE: accepting requests.
- WAIT: latency counter runs from MEM_LAT-1 down to 0.
- RESP: the rvalid cycle.
- Transitions: IDLE->WAIT on a grant. WAIT->RESP when the counter reaches 0 and mem_rdata is valid. RESP->WAIT if a grant is issued in the RESP cycle, otherwise RESP->IDLE.
- Grants are permitted in IDLE and RESP only.

Grant rule:
- Grants are combinational from req in grant-permitted states.
- Exactly one of if_gnt/d_gnt is high per cycle, or neither.
- Both are 0 while rst is low.
- Handshake is complete when req && gnt in the same cycle.
- The requester must hold req, addr, we, be and wdata stable until gnt.
- After gnt the requester may deassert req or present a new request.

Arbitration:
- Data wins when both request.
- Exception: fetch wins if starve_cnt == STARVE_MAX.
- starve_cnt increments when if_req is high and not granted in a grant-permitted cycle.
- starve_cnt clears on if_gnt or when if_req is low.
- starve_cnt saturates at STARVE_MAX.

Memory issue:
- mem_en is high in the grant cycle; mem_addr/mem_we/mem_be/mem_wdata mux the winner's signals.
- For a fetch, mem_we=0 and mem_be=all ones.
- When mem_en=0, all mem_* outputs are 0.

Response:
- The winner's rdata is a registered copy of mem_rdata.
- The winner's rvalid pulses for exactly one cycle at T+MEM_LAT+1, where T is the grant cycle.
- Writes pulse d_rvalid at the same point with d_rdata=0.
- rdata holds its last value when rvalid=0.
- The maximum back-to-back rate is one grant every MEM_LAT+1 cycles, because the next grant may coincide with the RESP cycle.

busy:
- Asserted from the cycle after a grant through the RESP cycle.
- Stays high continuously across back-to-back grants.

Reset:
- While rst is low, everything is forced to 0: all outputs, state=IDLE, counters.
- Reset mid-transaction drops the access with no rvalid afterwards.
- After rst rises, the first request may be granted in the next rising-edge cycle.

Simultaneous events:
- A new request arriving during WAIT is ignored until RESP.
- The requester that just received rvalid may be re-granted in the same RESP cycle.

Test Plan:
1. Single fetch, MEM_LAT=2, if_addr=0x10, model mem[0x10]=0x00500093, grant at T -> mem_en=1, mem_addr=0x10 at T; if_rvalid=1 with if_rdata=0x00500093 at T+3 only; busy high T+1..T+3.
2. if_req and d_req (read 0x200) both rise at T -> d_gnt at T, d_rvalid at T+3; if_gnt at T+3, if_rvalid at T+6; if_gnt never coincides with d_gnt.
3. Starvation, STARVE_MAX=4, d_req and if_req held high -> four consecutive d_gnt, fifth grant is if_gnt, starve_cnt returns to 0, then d_gnt resumes.
4. Write d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF over model contents 0x11223344 -> mem_we=1, mem_be=0011 at T; d_rvalid at T+3 with d_rdata=0; read of 0x100 afterwards returns 0x1122BEEF.
5. rst driven low at T+1 after a fetch grant -> all outputs 0 immediately, no if_rvalid at T+3; after release, a new fetch completes with normal timing.
6. MEM_LAT=1, if_req held with addresses 0x0, 0x4, 0x8 -> grants at T, T+2, T+4; rvalids at T+2, T+4, T+6 with matching data; busy constantly high from T+1 to T+6.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - fetch/load-store arbiter for a shared fixed-latency memory
// One outstanding access; data port preferred, fetch wins after STARVE_MAX lost rounds.
module cpu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        starve_q;
  logic              owner_d_q;
  logic              owner_we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_ok;
  logic              fetch_wins;
  logic              any_gnt;
  logic              capture;

  // Grants are only legal when no access is mid-flight and reset is released.
  always_comb begin
    grant_ok   = rst && (state_q == IDLE || state_q == RESP);
    fetch_wins = (starve_q == SMAX);
    if_gnt     = grant_ok && if_req && (!d_req || fetch_wins);
    d_gnt      = grant_ok && d_req && !(if_req && fetch_wins);
    any_gnt    = if_gnt || d_gnt;
    capture    = (state_q == WAIT) && (cnt_q == 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = any_gnt ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      owner_d_q  <= 1'b0;
      owner_we_q <= 1'b0;
    end else if (any_gnt) begin
      cnt_q      <= LAT_M1;
      owner_d_q  <= d_gnt;
      owner_we_q <= d_gnt && d_we;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Read data is sampled on the last WAIT cycle; write completions return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (owner_d_q) begin
        d_rdata_q <= owner_we_q ? '0 : mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_q <= 4'd0;
    end else if (grant_ok && starve_q != SMAX) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  always_comb begin
    if_rvalid = (state_q == RESP) && !owner_d_q;
    d_rvalid  = (state_q == RESP) && owner_d_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != IDLE);
    mem_en    = any_gnt;
    mem_we    = d_gnt && d_we;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_be   = {BE_W{1'b1}};
      mem_addr = if_addr;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
  logic [3:0]  b_d_be;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  logic [31:0] mem [0:255];
  logic [31:0] ra1, ra2, rb1;
  int          passes = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory macro model: contents reload while reset is low, read data delayed MEM_LAT cycles.
  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h00] <= 32'h11110000;
      mem[8'h01] <= 32'h22220004;
      mem[8'h02] <= 32'h33330008;
      mem[8'h04] <= 32'h00500093;
      mem[8'h05] <= 32'h55550014;
      mem[8'h08] <= 32'h88880020;
      mem[8'h40] <= 32'h11223344;
      mem[8'h80] <= 32'hA5A50200;
      mem[8'hC0] <= 32'h33000300;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    ra1 <= mem[mem_addr[9:2]];
    ra2 <= ra1;
    rb1 <= mem[b_mem_addr[9:2]];
  end

  assign mem_rdata   = ra2;
  assign b_mem_rdata = rb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_be = 4'h0; b_d_addr = '0; b_d_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("f1_gnt", {30'd0, if_gnt, d_gnt}, 32'h2);
    chk("f1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("f1_mem_addr", mem_addr, 32'h10);
    chk("f1_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    chk("f1_busy_T", {31'd0, busy}, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("f1_busy_T1", {30'd0, busy, if_rvalid}, 32'h2);
    chk("f1_mem_idle", {mem_addr[30:0], mem_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("f1_busy_T2", {30'd0, busy, if_rvalid}, 32'h2);
    @(negedge clk);
    #1;
    chk("f1_busy_T3", {30'd0, busy, if_rvalid}, 32'h3);
    chk("f1_rdata", if_rdata, 32'h00500093);
    @(negedge clk);
    #1;
    chk("f1_done", {30'd0, busy, if_rvalid}, 32'h0);
    chk("f1_rdata_hold", if_rdata, 32'h00500093);

    // both request together: data first, fetch granted in data's RESP cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
    #1;
    chk("p_gnt_T", {30'd0, if_gnt, d_gnt}, 32'h1);
    chk("p_mem_addr_T", mem_addr, 32'h200);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("p_gnt_wait", {30'd0, if_gnt, d_gnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("p_d_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'h2);
    chk("p_d_rdata", d_rdata, 32'hA5A50200);
    chk("p_gnt_T3", {30'd0, if_gnt, d_gnt}, 32'h2);
    chk("p_mem_addr_T3", mem_addr, 32'h14);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("p_busy_T4", {29'd0, busy, d_rvalid, if_rvalid}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("p_if_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'h1);
    chk("p_if_rdata", if_rdata, 32'h55550014);
    @(negedge clk);
    #1;
    chk("p_idle", {31'd0, busy}, 32'd0);

    // starvation guard: four data wins, then fetch, then data again
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h20;
    #1;
    chk("s_gnt0", {30'd0, if_gnt, d_gnt}, 32'h1);
    for (int i = 1; i < 6; i++) begin
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("s_gnt%0d", i), {30'd0, if_gnt, d_gnt}, (i == 4) ? 32'h2 : 32'h1);
      if (i == 4) chk("s_fetch_addr", mem_addr, 32'h20);
    end
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b0;
    repeat (3) @(negedge clk);

    // partial write then read-back
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    #1;
    chk("w_gnt", {30'd0, if_gnt, d_gnt}, 32'h1);
    chk("w_mem_we_be", {27'd0, mem_we, mem_be}, 32'h13);
    chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("w_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("w_rdata_zero", d_rdata, 32'd0);
    @(negedge clk);
    d_req = 1'b1;
    #1;
    chk("r_gnt", {28'd0, d_gnt, mem_we, mem_en, if_gnt}, 32'hA);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("r_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("r_rdata", d_rdata, 32'h1122BEEF);

    // reset in the middle of a fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("x_gnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0; rst = 1'b0;
    #1;
    chk("x_busy", {31'd0, busy}, 32'd0);
    chk("x_d_rdata", d_rdata, 32'd0);
    chk("x_if_rdata", if_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("x_no_rvalid", {30'd0, busy, if_rvalid}, 32'h0);
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk("x2_gnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("x2_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("x2_rdata", if_rdata, 32'h00500093);

    // MEM_LAT=1 back-to-back fetches
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = 32'h0;
    #1;
    chk("b_gnt_T", {30'd0, b_if_gnt, b_busy}, 32'h2);
    @(negedge clk);
    b_if_addr = 32'h4;
    #1;
    chk("b_T1", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h2);
    @(negedge clk);
    #1;
    chk("b_T2", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h7);
    chk("b_T2_data", b_if_rdata, 32'h11110000);
    chk("b_T2_addr", b_mem_addr, 32'h4);
    @(negedge clk);
    b_if_addr = 32'h8;
    #1;
    chk("b_T3", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h2);
    @(negedge clk);
    #1;
    chk("b_T4", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h7);
    chk("b_T4_data", b_if_rdata, 32'h22220004);
    chk("b_T4_addr", b_mem_addr, 32'h8);
    @(negedge clk);
    b_if_req = 1'b0;
    #1;
    chk("b_T5", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h2);
    @(negedge clk);
    #1;
    chk("b_T6", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h3);
    chk("b_T6_data", b_if_rdata, 32'h33330008);
    @(negedge clk);
    #1;
    chk("b_T7", {29'd0, b_if_gnt, b_busy, b_if_rvalid}, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
